tile_axi_single_initiator: RTL and testbench



---
 rtl/tile_axi_single_initiator.sv | 182 ++++++++++++++++++
 tb/tb_tile_axi_single_initiator.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_axi_single_initiator.sv
// Single-outstanding AXI4 initiator: turns a valid/ready memory request into one
// single-beat AXI read or write and returns the data and error status.
`timescale 1ns/1ps
module tile_axi_single_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [ADDR_W-1:0]   aw_addr_o,
    output logic [ID_W-1:0]     aw_id_o,
    output logic [7:0]          aw_len_o,
    output logic [2:0]          aw_size_o,
    output logic [1:0]          aw_burst_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W/8-1:0] w_strb_o,
    output logic                w_last_o,
    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [1:0]          b_resp_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [ADDR_W-1:0]   ar_addr_o,
    output logic [ID_W-1:0]     ar_id_o,
    output logic [7:0]          ar_len_o,
    output logic [2:0]          ar_size_o,
    output logic [1:0]          ar_burst_o,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    input  logic [DATA_W-1:0]   r_data_i,
    input  logic [1:0]          r_resp_i,
    input  logic                r_last_i,
    output logic [15:0]         err_count_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WR_B  = 3'd2;
    localparam logic [2:0] S_RD_AR = 3'd3;
    localparam logic [2:0] S_RD_R  = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    localparam logic [2:0] AXI_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                we_q, we_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                rsp_cap;

    // Every handshake-facing output is a pure decode of registered state.
    assign req_ready_o = (state_q == S_IDLE);
    assign aw_valid_o  = (state_q == S_WR) && !aw_done_q;
    assign w_valid_o   = (state_q == S_WR) && !w_done_q;
    assign b_ready_o   = (state_q == S_WR_B);
    assign ar_valid_o  = (state_q == S_RD_AR);
    assign r_ready_o   = (state_q == S_RD_R);
    assign rsp_valid_o = (state_q == S_RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign err_count_o = err_cnt_q;

    assign aw_addr_o  = addr_q;
    assign aw_id_o    = '0;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = AXI_SIZE;
    assign aw_burst_o = 2'b01;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_last_o   = 1'b1;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = '0;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = AXI_SIZE;
    assign ar_burst_o = 2'b01;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        rsp_cap   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    be_d      = req_be_i;
                    we_d      = req_we_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    state_d   = req_we_i ? S_WR : S_RD_AR;
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | (aw_valid_o & aw_ready_i);
                w_done_d  = w_done_q | (w_valid_o & w_ready_i);
                if (aw_done_d && w_done_d) state_d = S_WR_B;
            end
            S_WR_B: begin
                if (b_valid_i) begin
                    err_d   = (b_resp_i != 2'b00);
                    rsp_cap = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RD_AR: begin
                if (ar_ready_i) state_d = S_RD_R;
            end
            S_RD_R: begin
                if (r_valid_i) begin
                    rdata_d = r_data_i;
                    // A single-beat read that is not marked last is malformed.
                    err_d   = (r_resp_i != 2'b00) || !r_last_i;
                    rsp_cap = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rsp_cap && err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_tile_axi_single_initiator.sv
// Directed bench: AXI responder model plus a response scoreboard fed by the driver.
`timescale 1ns/1ps
module tb_tile_axi_single_initiator;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        aw_valid_o, aw_ready_i;
    logic [31:0] aw_addr_o;
    logic [0:0]  aw_id_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o, w_ready_i, w_last_o;
    logic [31:0] w_data_o;
    logic [3:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        ar_valid_o, ar_ready_i;
    logic [31:0] ar_addr_o;
    logic [0:0]  ar_id_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        r_valid_i, r_ready_o, r_last_i;
    logic [31:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic [15:0] err_count_o;

    tile_axi_single_initiator dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Responder knobs and per-transaction observations
    int          aw_delay = 0;
    logic        b_hold = 1'b0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic        r_last_cfg = 1'b1;
    logic [31:0] mem [logic [31:0]];
    logic        aw_got, w_got, rd_pend;
    int          aw_wait, ncyc, aw_cyc, w_cyc, b_cyc, aw_first, w_first;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [7:0]  cap_len, print_ch;
    logic [2:0]  cap_size;
    logic [1:0]  cap_burst;
    logic [3:0]  cap_strb;
    logic        cap_wlast, cap_id;

    task automatic clr_stats();
        aw_cyc = 0; w_cyc = 0; b_cyc = 0; aw_first = -1; w_first = -1; aw_wait = 0;
    endtask

    initial begin
        aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
        ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_last_i = 0;
        aw_got = 0; w_got = 0; rd_pend = 0; ncyc = 0; print_ch = 0;
        clr_stats();
        forever begin
            @(negedge clk);
            ncyc++;
            b_valid_i = 1'b0;
            r_valid_i = 1'b0;
            if (b_ready_o) b_cyc++;
            if (aw_got && w_got && b_ready_o && !b_hold) begin
                logic [31:0] old;
                old = mem.exists(cap_awaddr) ? mem[cap_awaddr] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (cap_strb[i]) old[i*8 +: 8] = cap_wdata[i*8 +: 8];
                mem[cap_awaddr] = old;
                if (cap_awaddr == 32'h2FFF_0004) print_ch = cap_wdata[7:0];
                b_valid_i = 1'b1; b_resp_i = b_resp_cfg;
                aw_got = 0; w_got = 0;
            end
            if (rd_pend && r_ready_o) begin
                r_valid_i = 1'b1;
                r_data_i  = mem.exists(cap_araddr) ? mem[cap_araddr] : 32'h0;
                r_resp_i  = r_resp_cfg;
                r_last_i  = r_last_cfg;
                rd_pend   = 0;
            end
            aw_ready_i = 1'b0;
            if (aw_valid_o) begin
                if (aw_cyc == 0) aw_first = ncyc;
                aw_cyc++;
                if (aw_wait == aw_delay) begin
                    aw_ready_i = 1'b1; aw_wait = 0; aw_got = 1;
                    cap_awaddr = aw_addr_o; cap_len = aw_len_o; cap_size = aw_size_o;
                    cap_burst = aw_burst_o; cap_id = aw_id_o[0];
                end else aw_wait++;
            end
            w_ready_i = 1'b0;
            if (w_valid_o) begin
                if (w_cyc == 0) w_first = ncyc;
                w_cyc++;
                w_ready_i = 1'b1; w_got = 1;
                cap_wdata = w_data_o; cap_strb = w_strb_o; cap_wlast = w_last_o;
            end
            ar_ready_i = 1'b0;
            if (ar_valid_o) begin
                ar_ready_i = 1'b1; rd_pend = 1; cap_araddr = ar_addr_o;
            end
        end
    end

    // Scoreboard monitor: pops on every response handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_rdata", {32'h0, rsp_rdata_o}, {32'h0, e.rdata});
                    chk("rsp_err", {63'h0, rsp_err_o}, {63'h0, e.err});
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input logic expect_rsp, input logic keep);
        int t;
        @(negedge clk);
        req_we_i = we; req_addr_i = addr; req_wdata_i = data; req_be_i = be;
        req_valid_i = 1'b1;
        t = 0;
        while (!req_ready_o && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("req_accept_timeout", 64'd1, 64'd0);
        if (expect_rsp) sb_q.push_back('{exp_rd, exp_err});
        @(posedge clk);
        #1;
        if (!keep) req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid_o && lat < 200) begin @(negedge clk); #1; lat++; end
        if (lat >= 200) chk("rsp_timeout", 64'd1, 64'd0);
    endtask

    int   lat;
    logic ok;

    initial begin
        rst_i = 1'b1; req_valid_i = 0; req_we_i = 0; req_addr_i = 0; req_wdata_i = 0;
        req_be_i = 0; rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", {63'h0, req_ready_o}, 64'd1);
        chk("rst_valids", {58'h0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, rsp_valid_o}, 64'd0);
        chk("rst_rsp_data", {31'h0, rsp_err_o, rsp_rdata_o}, 64'd0);
        chk("rst_err_count", {48'h0, err_count_o}, 64'd0);
        @(negedge clk);
        rst_i = 1'b0;

        // Print-address write, zero-wait responder
        clr_stats();
        send(1, 32'h2FFF_0004, 32'h41, 4'hF, 32'h0, 0, 1, 0);
        wait_rsp(lat);
        chk("print_latency", lat, 64'd3);
        chk("print_aw_w_same_cycle", aw_first, w_first);
        chk("print_awaddr", {32'h0, cap_awaddr}, 64'h2FFF_0004);
        chk("print_fields", {cap_len, 1'b0, cap_size, 2'b0, cap_burst, 3'b0, cap_id, cap_strb, 3'b0, cap_wlast},
            {8'h00, 1'b0, 3'd2, 2'b0, 2'b01, 3'b0, 1'b0, 4'hF, 3'b0, 1'b1});
        chk("print_char", {56'h0, print_ch}, 64'h41);

        // Write then read back
        send(1, 32'h2C00_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1, 0);
        wait_rsp(lat);
        chk("wr_latency", lat, 64'd3);
        send(0, 32'h2C00_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1, 0);
        wait_rsp(lat);
        chk("rd_latency", lat, 64'd3);
        chk("rd_araddr", {32'h0, cap_araddr}, 64'h2C00_0100);

        // AW ready delayed by 4 cycles, W ready immediately
        clr_stats();
        aw_delay = 4;
        send(1, 32'h2C00_0200, 32'h1234_5678, 4'h3, 32'h0, 0, 1, 0);
        wait_rsp(lat);
        aw_delay = 0;
        chk("dly_aw_cycles", aw_cyc, 64'd5);
        chk("dly_w_cycles", w_cyc, 64'd1);
        chk("dly_b_cycles", b_cyc, 64'd1);
        chk("dly_latency", lat, 64'd7);
        chk("dly_strb", {60'h0, cap_strb}, 64'h3);

        // Error responses and counter saturation
        b_resp_cfg = 2'b10;
        send(1, 32'h2C00_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 1, 0);
        wait_rsp(lat);
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
        send(0, 32'h2C00_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1, 0);
        wait_rsp(lat);
        r_resp_cfg = 2'b00;
        @(negedge clk); #1;
        chk("err_count_2", {48'h0, err_count_o}, 64'd2);
        r_last_cfg = 1'b0;
        send(0, 32'h2C00_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1, 0);
        wait_rsp(lat);
        r_last_cfg = 1'b1;
        @(negedge clk); #1;
        chk("err_count_rlast", {48'h0, err_count_o}, 64'd3);
        force dut.err_cnt_q = 16'hFFFF;
        #1;
        release dut.err_cnt_q;
        b_resp_cfg = 2'b10;
        send(1, 32'h2C00_0100, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 1, 0);
        wait_rsp(lat);
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
        send(0, 32'h2C00_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1, 0);
        wait_rsp(lat);
        r_resp_cfg = 2'b00;
        @(negedge clk); #1;
        chk("err_count_sat", {48'h0, err_count_o}, 64'hFFFF);

        // Response back-pressure with the next request already pending
        rsp_ready_i = 1'b0;
        send(0, 32'h2C00_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1, 1);
        wait_rsp(lat);
        chk("hold_latency", lat, 64'd3);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!(rsp_valid_o && rsp_rdata_o == 32'hDEAD_BEEF && !rsp_err_o && !req_ready_o
                  && !aw_valid_o && !ar_valid_o)) ok = 1'b0;
        end
        chk("hold_stable", {63'h0, ok}, 64'd1);
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("hold_idle_ready", {63'h0, req_ready_o}, 64'd1);
        chk("hold_no_early_ar", {63'h0, ar_valid_o}, 64'd0);
        sb_q.push_back('{32'hDEAD_BEEF, 1'b0});
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        chk("hold_next_ar", {63'h0, ar_valid_o}, 64'd1);
        wait_rsp(lat);
        chk("hold_next_latency", lat, 64'd3);

        // Reset while waiting on B
        b_hold = 1'b1;
        send(1, 32'h2C00_0300, 32'h5555_AAAA, 4'hF, 32'h0, 0, 0, 0);
        lat = 0;
        while (!b_ready_o && lat < 50) begin @(negedge clk); #1; lat++; end
        chk("rst_mid_in_wr_b", {63'h0, b_ready_o}, 64'd1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_valids", {58'h0, aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, rsp_valid_o}, 64'd0);
        chk("rst_mid_err_count", {48'h0, err_count_o}, 64'd0);
        @(negedge clk);
        rst_i = 1'b0; b_hold = 1'b0; aw_got = 0; w_got = 0; rd_pend = 0;
        ok = 1'b1;
        repeat (5) begin @(negedge clk); #1; if (rsp_valid_o) ok = 1'b0; end
        chk("rst_mid_no_rsp", {63'h0, ok}, 64'd1);
        send(1, 32'h2C00_0300, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 1, 0);
        wait_rsp(lat);
        chk("post_rst_latency", lat, 64'd3);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
